// File: rtl/eth_disp_ctrl_pkg.sv
// Shared definitions for the Ethernet display controller and the receive path
// that produces its command bytes: mode encodings, command bytes, decode helper.
package eth_disp_ctrl_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE   = 3'd0,
    MODE_UP     = 3'd1,
    MODE_DOWN   = 3'd2,
    MODE_BLINK  = 3'd3,
    MODE_ROTATE = 3'd4
  } mode_e;

  localparam logic [7:0] CMD_IDLE   = 8'h00;
  localparam logic [7:0] CMD_UP     = 8'hAA;
  localparam logic [7:0] CMD_DOWN   = 8'hDD;
  localparam logic [7:0] CMD_BLINK  = 8'hBB;
  localparam logic [7:0] CMD_ROTATE = 8'hCC;

  // Glyph shown for digit 0; also the segment reset pattern.
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  typedef struct packed {
    logic  hit;
    mode_e mode;
  } cmd_dec_t;

  // Map a command byte to its mode; hit is low for bytes that are not commands.
  function automatic cmd_dec_t decode_cmd(input logic [7:0] data);
    cmd_dec_t r;
    r.hit  = 1'b1;
    r.mode = MODE_IDLE;
    case (data)
      CMD_IDLE:   r.mode = MODE_IDLE;
      CMD_UP:     r.mode = MODE_UP;
      CMD_DOWN:   r.mode = MODE_DOWN;
      CMD_BLINK:  r.mode = MODE_BLINK;
      CMD_ROTATE: r.mode = MODE_ROTATE;
      default:    r.hit  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/eth_disp_ctrl_hex_to_seg.sv
// Hex nibble to common-anode seven-segment glyph, segments ordered {g..a}, active-low.
module hex_to_seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Combinational font lookup.
  always_comb begin
    case (hex_i)
      4'h0:    seg_o = 7'b1000000;
      4'h1:    seg_o = 7'b1111001;
      4'h2:    seg_o = 7'b0100100;
      4'h3:    seg_o = 7'b0110000;
      4'h4:    seg_o = 7'b0011001;
      4'h5:    seg_o = 7'b0010010;
      4'h6:    seg_o = 7'b0000010;
      4'h7:    seg_o = 7'b1111000;
      4'h8:    seg_o = 7'b0000000;
      4'h9:    seg_o = 7'b0010000;
      4'hA:    seg_o = 7'b0001000;
      4'hB:    seg_o = 7'b0000011;
      4'hC:    seg_o = 7'b1000110;
      4'hD:    seg_o = 7'b0100001;
      4'hE:    seg_o = 7'b0000110;
      4'hF:    seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/eth_disp_ctrl.sv
// Command-driven display controller: a mode set by Ethernet command bytes drives
// a hex counter shown on a multiplexed seven-segment display and an LED pattern.
module eth_disp_ctrl
  import eth_disp_ctrl_pkg::*;
#(
  parameter int TICK_CYCLES = 60_000_000,
  parameter int SCAN_CYCLES = 50_000,
  parameter int DIGITS      = 4,
  parameter int LED_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        eth_data,
  input  logic              eth_valid,
  input  logic              flag,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] sel,
  output logic [LED_W-1:0]  led,
  output logic [2:0]        mode
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;
  localparam logic [LED_W-1:0] LED_MSB = {1'b1, {(LED_W-1){1'b0}}};

  logic [TW-1:0]     tick_cnt_q;
  logic [SW-1:0]     scan_cnt_q;
  logic [DW-1:0]     idx_q;
  logic [VW-1:0]     value_q, value_d;
  logic [LED_W-1:0]  led_q, led_d;
  mode_e             mode_q, mode_d;
  logic [6:0]        seg_q;
  logic [DIGITS-1:0] sel_q;

  logic              tick_s;
  logic              scan_wrap_s;
  cmd_dec_t          cmd_s;
  logic              cmd_take_s;
  logic [3:0]        nibble_s;
  logic [6:0]        glyph_s;

  // Timer wrap strobes, command acceptance and the nibble under the scan index.
  always_comb begin
    tick_s      = (tick_cnt_q == TW'(TICK_CYCLES - 1));
    scan_wrap_s = (scan_cnt_q == SW'(SCAN_CYCLES - 1));
    cmd_s       = decode_cmd(eth_data);
    // Only a command that actually changes mode has any effect.
    cmd_take_s  = eth_valid && cmd_s.hit && (cmd_s.mode != mode_q);
    nibble_s    = 4'(value_q >> {idx_q, 2'b00});
  end

  hex_to_seg u_hex_to_seg (
    .hex_i (nibble_s),
    .seg_o (glyph_s)
  );

  // Next mode, counter value and LED pattern; flag wins over commands and ticks.
  always_comb begin
    mode_d  = mode_q;
    value_d = value_q;
    led_d   = led_q;
    if (flag) begin
      value_d = '0;
      led_d   = '0;
    end else begin
      if (tick_s && (mode_q == MODE_UP)) begin
        value_d = value_q + VW'(1);
      end else if (tick_s && (mode_q == MODE_DOWN)) begin
        value_d = value_q - VW'(1);
      end else begin
        value_d = value_q;
      end
      if (cmd_take_s) begin
        mode_d = cmd_s.mode;
        led_d  = '0;
      end else begin
        case (mode_q)
          MODE_BLINK:  led_d = tick_s ? ~led_q : led_q;
          MODE_ROTATE: begin
            // A degenerate pattern (none or all lit) is reseeded immediately.
            if ((~|led_q) || (&led_q)) begin
              led_d = LED_MSB;
            end else if (tick_s) begin
              led_d = {led_q[0], led_q[LED_W-1:1]};
            end else begin
              led_d = led_q;
            end
          end
          default:     led_d = '0;
        endcase
      end
    end
  end

  // Mode state machine with its counter value and LED pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= MODE_IDLE;
      value_q <= '0;
      led_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      value_q <= value_d;
      led_q   <= led_d;
    end
  end

  // Update-tick timer, scan-slot timer and digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      if (flag || tick_s) begin
        tick_cnt_q <= '0;
      end else begin
        tick_cnt_q <= tick_cnt_q + TW'(1);
      end
      if (flag || scan_wrap_s) begin
        scan_cnt_q <= '0;
      end else begin
        scan_cnt_q <= scan_cnt_q + SW'(1);
      end
      // The digit index is not part of the flag clear; it keeps scanning.
      if (scan_wrap_s) begin
        idx_q <= (idx_q == DW'(DIGITS - 1)) ? '0 : idx_q + DW'(1);
      end else begin
        idx_q <= idx_q;
      end
    end
  end

  // Registered digit select and segment drive for the current index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= SEG_ZERO;
      sel_q <= ~(DIGITS'(1));
    end else begin
      seg_q <= glyph_s;
      sel_q <= ~(DIGITS'(1) << idx_q);
    end
  end

  assign seg  = seg_q;
  assign sel  = sel_q;
  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: doc/eth_disp_ctrl.md
ETH_DISP_CTRL -- requirements
Module: eth_disp_ctrl

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 60_000_000, meaning clk cycles per update tick.
REQ-002 SHALL have parameter SCAN_CYCLES, default 50_000, meaning clk cycles per digit scan slot.
REQ-003 SHALL have parameter DIGITS, default 4, legal 1..8, meaning number of scanned hex digits.
REQ-004 SHALL have parameter LED_W, default 4, legal 2..16, meaning LED count.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port eth_data  input  8  command byte.
REQ-008 SHALL have port eth_valid  input  1  one-cycle strobe qualifying eth_data.
REQ-009 SHALL have port flag  input  1  synchronous clear of value, LEDs and timers.
REQ-010 SHALL have port seg  output  7  active-low segments {g..a} of the selected digit.
REQ-011 SHALL have port sel  output  DIGITS  active-low one-hot digit select.
REQ-012 SHALL have port led  output  LED_W  LED drive, active-high.
REQ-013 SHALL have port mode  output  3  current mode encoding, for status.

Function
REQ-014 SHALL hold mode in {IDLE=0, UP=1, DOWN=2, BLINK=3, ROTATE=4}; commands on eth_valid: 0x00->IDLE, 0xAA->UP, 0xDD->DOWN, 0xBB->BLINK, 0xCC->ROTATE; any other byte ignored, mode unchanged.
REQ-015 SHALL update mode the cycle after the accepting edge; repeating the current command SHALL change nothing.
REQ-016 SHALL run a tick counter 0..TICK_CYCLES-1, wrapping; tick asserted for the one cycle at TICK_CYCLES-1.
REQ-017 SHALL keep a value register of 4*DIGITS bits: UP adds 1 on tick, DOWN subtracts 1 on tick, modulo 2^(4*DIGITS) (all-F wraps to 0, 0 wraps to all-F); held in all other modes.
REQ-018 SHALL, on accepting a command that changes mode, clear led to 0 in that cycle.
REQ-019 SHALL in BLINK invert all led bits on tick.
REQ-020 SHALL in ROTATE load led with MSB-only one-hot on the cycle led is all-0 or all-1, otherwise rotate right by one (LSB to MSB) on tick.
REQ-021 SHALL force led to 0 in IDLE, UP and DOWN.
REQ-022 SHALL give flag priority over eth_valid and tick: in a flag cycle tick counter, scan counter, value and led clear to 0, any command is dropped, mode held.
REQ-023 SHALL run a scan counter 0..SCAN_CYCLES-1 and a digit index 0..DIGITS-1 advancing on scan wrap, index wrapping to 0 after DIGITS-1.
REQ-024 SHALL register seg and sel: one cycle after index i, sel has only bit i low and seg shows nibble value[4i+3:4i] in the standard common-anode hex font (0 = 7'b1000000, F = 7'b0001110).
REQ-025 SHALL keep sel strictly one-hot-low after reset (never two digits enabled).

Reset
REQ-026 SHALL on rst_n low at a clk edge set mode IDLE, value 0, led 0, tick and scan counters 0, index 0, sel with only bit 0 low, seg = glyph 0.
REQ-027 SHALL, on reset mid-operation, abandon all state in one cycle with no command remembered.

Structure
REQ-028 SHALL place mode encodings and command byte constants in a shared package used by this block and the Ethernet receive path.
REQ-029 SHALL implement the hex-to-segment decode as sub-module hex_to_seg (4-bit in, 7-bit active-low out, combinational).
REQ-030 SHALL size counters with $clog2 of their parameters.

Verification (TICK_CYCLES=4, SCAN_CYCLES=2, DIGITS=4, LED_W=4)
REQ-031 SHALL test: reset, 0xAA strobe, run 40 cycles -> value 0x000A, mode 1, led 0.
REQ-032 SHALL test: value 0, 0xDD strobe, one tick -> value 0xFFFF; sel scans 1110,1101,1011,0111 every 2 cycles with seg 0001110.
REQ-033 SHALL test: 0xCC strobe -> led 1000 one cycle later, then 0100, 0010, 0001, 1000 on successive ticks.
REQ-034 SHALL test: 0xBB with led 0 -> led 1111, 0000, 1111 on successive ticks; strobe 0x55 -> mode stays 3.
REQ-035 SHALL test: flag and eth_valid=0xAA in same cycle during DOWN -> value 0, led 0, mode stays 2.
REQ-036 SHALL test: rst_n low mid-ROTATE for one cycle -> all REQ-026 values next cycle.
